// File: rtl/go_pkg.sv
// Shared Go board types: cell encoding, board shape, coordinate layout.
// The board updater and the capture/prisoner logic both build on these.
package go_pkg;
  typedef logic [1:0] cell_t;

  localparam cell_t EMPTY = 2'b00;
  localparam cell_t BLACK = 2'b01;
  localparam cell_t WHITE = 2'b10;
  localparam int    BOARD_N = 9;

  typedef cell_t [BOARD_N-1:0][BOARD_N-1:0] board_t;

  // Same bit layout as move_in / ko_point: {row[7:4], col[3:0]}.
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } coord_t;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SCAN, S_FINISH} state_t;
endpackage

// File: rtl/capture_tally_ko_detect.sv
// Combinational simple-ko neighbour check on the latched post-move board.
// Hit when every on-board neighbour of the move is opponent colour except the ko candidate.
module ko_detect import go_pkg::*; #(
  parameter int N = 9
) (
  input  logic [N-1:0][N-1:0][1:0] i_board,
  input  logic [7:0]               i_move,
  input  logic [7:0]               i_cand,
  input  logic [1:0]               i_opp,
  output logic                     o_hit
);
  coord_t     w_mv, w_cd;
  logic       w_in;
  logic [3:0] w_nr [4];
  logic [3:0] w_nc [4];
  logic       w_onb [4];
  logic       w_ok, w_any, w_is_cd;

  assign w_mv = coord_t'(i_move);
  assign w_cd = coord_t'(i_cand);
  assign w_in = (w_mv.row < 4'(N)) && (w_mv.col < 4'(N));

  always_comb begin
    w_nr[0] = w_mv.row - 4'd1; w_nc[0] = w_mv.col;
    w_nr[1] = w_mv.row + 4'd1; w_nc[1] = w_mv.col;
    w_nr[2] = w_mv.row;        w_nc[2] = w_mv.col - 4'd1;
    w_nr[3] = w_mv.row;        w_nc[3] = w_mv.col + 4'd1;
    w_onb[0] = w_in && (w_mv.row != 4'd0);
    w_onb[1] = w_in && (w_mv.row <  4'(N-1));
    w_onb[2] = w_in && (w_mv.col != 4'd0);
    w_onb[3] = w_in && (w_mv.col <  4'(N-1));
    w_ok    = 1'b1;
    w_any   = 1'b0;
    w_is_cd = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (w_onb[d]) begin
        w_is_cd = (w_nr[d] == w_cd.row) && (w_nc[d] == w_cd.col);
        w_ok    = w_ok && (w_is_cd || (i_board[w_nr[d]][w_nc[d]] == i_opp));
        w_any   = w_any || w_is_cd;
      end
    end
    o_hit = w_in && w_ok && w_any;
  end
endmodule

// File: rtl/capture_tally.sv
// Post-move capture counter: scans old vs pruned board one cell per clock,
// accumulates saturating prisoner totals per colour and flags simple ko.
module capture_tally import go_pkg::*; #(
  parameter int BOARD_N = 9,
  parameter int TOTAL_W = 8
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  start_flag,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  prev_board,
  input  logic [BOARD_N-1:0][BOARD_N-1:0][1:0]  next_board,
  input  logic                                  turn,
  input  logic [7:0]                            move_in,
  input  logic                                  clear_totals,
  output logic                                  busy,
  output logic                                  done,
  output logic [6:0]                            captured_last,
  output logic [6:0]                            suicide_last,
  output logic [TOTAL_W-1:0]                    black_prisoners,
  output logic [TOTAL_W-1:0]                    white_prisoners,
  output logic                                  ko_valid,
  output logic [7:0]                            ko_point
);
  localparam logic [31:0] SAT_MAX = (32'd1 << TOTAL_W) - 32'd1;

  state_t r_state, w_next;
  logic [BOARD_N-1:0][BOARD_N-1:0][1:0] r_prev, r_next;
  logic       r_turn, r_clr_pend;
  logic [7:0] r_move, r_cand;
  logic [3:0] r_row, r_col;
  logic [6:0] r_cap, r_sui;

  cell_t       w_mov, w_opp, w_pc, w_nc;
  logic        w_last, w_ko_hit;
  logic [6:0]  w_badd, w_wadd;
  logic [31:0] w_bsum, w_wsum;

  assign w_mov  = {r_turn, ~r_turn};
  assign w_opp  = {~r_turn, r_turn};
  assign w_pc   = r_prev[r_row][r_col];
  assign w_nc   = r_next[r_row][r_col];
  assign w_last = (r_row == 4'(BOARD_N-1)) && (r_col == 4'(BOARD_N-1));
  // Captures credit the mover, suicides credit the opponent.
  assign w_badd = r_turn ? r_sui : r_cap;
  assign w_wadd = r_turn ? r_cap : r_sui;
  assign w_bsum = 32'(black_prisoners) + 32'(w_badd);
  assign w_wsum = 32'(white_prisoners) + 32'(w_wadd);

  ko_detect #(.N(BOARD_N)) u_ko (
    .i_board (r_next),
    .i_move  (r_move),
    .i_cand  (r_cand),
    .i_opp   (w_opp),
    .o_hit   (w_ko_hit)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start_flag) w_next = S_LATCH;
      S_LATCH:  w_next = S_SCAN;
      S_SCAN:   if (w_last) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_prev <= '0; r_next <= '0; r_turn <= 1'b0; r_move <= '0;
      r_row <= '0; r_col <= '0; r_cap <= '0; r_sui <= '0; r_cand <= '0;
      r_clr_pend <= 1'b0;
      done <= 1'b0; captured_last <= '0; suicide_last <= '0;
      black_prisoners <= '0; white_prisoners <= '0;
      ko_valid <= 1'b0; ko_point <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear_totals) begin
            black_prisoners <= '0;
            white_prisoners <= '0;
          end
        end
        S_LATCH: begin
          r_prev <= prev_board; r_next <= next_board;
          r_turn <= turn;       r_move <= move_in;
          r_row <= '0; r_col <= '0; r_cap <= '0; r_sui <= '0; r_cand <= '0;
          if (clear_totals) r_clr_pend <= 1'b1;
        end
        S_SCAN: begin
          if (clear_totals) r_clr_pend <= 1'b1;
          if (w_nc == EMPTY) begin
            if (w_pc == w_opp) begin
              r_cap <= r_cap + 7'd1;
              if (r_cap == 7'd0) r_cand <= {r_row, r_col};
            end else if (w_pc == w_mov) begin
              r_sui <= r_sui + 7'd1;
            end
          end
          if (r_col == 4'(BOARD_N-1)) begin
            r_col <= '0;
            r_row <= r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        S_FINISH: begin
          captured_last <= r_cap;
          suicide_last  <= r_sui;
          // A clear requested mid-move wins over this move's additions.
          if (r_clr_pend || clear_totals) begin
            black_prisoners <= '0;
            white_prisoners <= '0;
          end else begin
            black_prisoners <= (w_bsum > SAT_MAX) ? SAT_MAX[TOTAL_W-1:0] : w_bsum[TOTAL_W-1:0];
            white_prisoners <= (w_wsum > SAT_MAX) ? SAT_MAX[TOTAL_W-1:0] : w_wsum[TOTAL_W-1:0];
          end
          r_clr_pend <= 1'b0;
          ko_valid   <= w_ko_hit && (r_cap == 7'd1) && (r_sui == 7'd0);
          ko_point   <= (w_ko_hit && (r_cap == 7'd1) && (r_sui == 7'd0)) ? r_cand : 8'h00;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_capture_tally.sv
// Scoreboard bench for capture_tally: expectations queued at stimulus time,
// popped and compared on each done pulse; scenario tasks add inline checks.
module tb_capture_tally;
  localparam int N  = 9;
  localparam int TW = 8;

  logic clk_in = 1'b0, rst_in = 1'b0, start_flag = 1'b0, turn = 1'b0, clear_totals = 1'b0;
  logic [N-1:0][N-1:0][1:0] prev_board = '0, next_board = '0;
  logic [7:0] move_in = 8'h00;
  logic busy, done, ko_valid;
  logic [6:0] captured_last, suicide_last;
  logic [TW-1:0] black_prisoners, white_prisoners;
  logic [7:0] ko_point;

  capture_tally #(.BOARD_N(N), .TOTAL_W(TW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_flag(start_flag),
    .prev_board(prev_board), .next_board(next_board), .turn(turn),
    .move_in(move_in), .clear_totals(clear_totals), .busy(busy), .done(done),
    .captured_last(captured_last), .suicide_last(suicide_last),
    .black_prisoners(black_prisoners), .white_prisoners(white_prisoners),
    .ko_valid(ko_valid), .ko_point(ko_point)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [6:0] cap, sui;
    logic [7:0] blk, wht;
    logic       kov;
    logic [7:0] kop;
  } exp_t;

  exp_t sb[$];
  int checks = 0, failures = 0;
  int exp_black = 0, exp_white = 0;

  function automatic int sat(int a, int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  task automatic expect_move(int cap, int sui, logic t, logic kov, logic [7:0] kop, bit clr);
    exp_t e;
    if (clr) begin
      exp_black = 0; exp_white = 0;
    end else if (!t) begin
      exp_black = sat(exp_black, cap); exp_white = sat(exp_white, sui);
    end else begin
      exp_white = sat(exp_white, cap); exp_black = sat(exp_black, sui);
    end
    e.cap = 7'(cap); e.sui = 7'(sui);
    e.blk = 8'(exp_black); e.wht = 8'(exp_white);
    e.kov = kov; e.kop = kop;
    sb.push_back(e);
  endtask

  // Scoreboard: every done pops one expectation.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in && done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: done=1 with no move outstanding");
      end else begin
        e = sb.pop_front();
        if (captured_last !== e.cap) begin failures++; $display("FAIL captured_last: got %0d want %0d", captured_last, e.cap); end
        checks++;
        if (suicide_last !== e.sui) begin failures++; $display("FAIL suicide_last: got %0d want %0d", suicide_last, e.sui); end
        checks++;
        if (black_prisoners !== e.blk) begin failures++; $display("FAIL black_prisoners: got %0d want %0d", black_prisoners, e.blk); end
        checks++;
        if (white_prisoners !== e.wht) begin failures++; $display("FAIL white_prisoners: got %0d want %0d", white_prisoners, e.wht); end
        checks++;
        if (ko_valid !== e.kov) begin failures++; $display("FAIL ko_valid: got %0b want %0b", ko_valid, e.kov); end
        checks++;
        if (ko_point !== e.kop) begin failures++; $display("FAIL ko_point: got %h want %h", ko_point, e.kop); end
      end
    end
  end

  task automatic start_move();
    @(negedge clk_in); start_flag = 1'b1;
    @(negedge clk_in); start_flag = 1'b0;
  endtask

  // Cycles counted from the start-sampling edge; 200 means no done seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = busy ? 1 : 0;
    while (cyc < 200) begin
      @(negedge clk_in);
      cyc++;
      if (busy) bcnt++;
      if (done) return;
    end
    cyc = 200;
  endtask

  task automatic clear_boards();
    prev_board = '0; next_board = '0;
  endtask

  task automatic set_single();
    clear_boards();
    prev_board[4][5] = 2'b10; prev_board[3][4] = 2'b01;
    next_board[4][4] = 2'b01; next_board[3][4] = 2'b01;
    turn = 1'b0; move_in = 8'h44;
  endtask

  task automatic set_ko(logic [7:0] mv);
    clear_boards();
    prev_board[4][5] = 2'b10;
    prev_board[3][4] = 2'b10; prev_board[5][4] = 2'b10; prev_board[4][3] = 2'b10;
    next_board[3][4] = 2'b10; next_board[5][4] = 2'b10; next_board[4][3] = 2'b10;
    next_board[4][4] = 2'b01;
    turn = 1'b0; move_in = mv;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if ({busy, done, captured_last, suicide_last, black_prisoners, white_prisoners, ko_valid, ko_point} !== '0) begin
      failures++; $display("FAIL reset_outputs: got busy=%0b done=%0b cap=%0d blk=%0d ko=%0b", busy, done, captured_last, black_prisoners, ko_valid);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_single_capture();
    int cyc, bcnt;
    set_single();
    expect_move(1, 0, 1'b0, 1'b0, 8'h00, 0);
    start_move();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 83) begin failures++; $display("FAIL single_latency: got %0d want 83", cyc); end
    checks++;
    if (bcnt !== 83) begin failures++; $display("FAIL single_busy_len: got %0d want 83", bcnt); end
  endtask

  task automatic test_ko();
    int cyc, bcnt;
    set_ko(8'h44);
    expect_move(1, 0, 1'b0, 1'b1, 8'h45, 0);
    start_move();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 83) begin failures++; $display("FAIL ko_latency: got %0d want 83", cyc); end
    repeat (5) @(negedge clk_in);
    checks++;
    if (ko_valid !== 1'b1 || ko_point !== 8'h45) begin
      failures++; $display("FAIL ko_hold: got valid=%0b point=%h want 1 45", ko_valid, ko_point);
    end
  endtask

  task automatic test_multi_capture();
    int cyc, bcnt;
    clear_boards();
    prev_board[0][0] = 2'b01; prev_board[0][1] = 2'b01; prev_board[1][0] = 2'b01;
    next_board[2][0] = 2'b10;
    prev_board[8][8] = 2'b11;                          // invalid old cell, now empty
    prev_board[7][7] = 2'b10; next_board[7][7] = 2'b11; // invalid new cell
    turn = 1'b1; move_in = 8'h20;
    expect_move(3, 0, 1'b1, 1'b0, 8'h00, 0);
    start_move();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 83) begin failures++; $display("FAIL multi_latency: got %0d want 83", cyc); end
  endtask

  task automatic test_suicide();
    int cyc, bcnt;
    clear_boards();
    prev_board[6][6] = 2'b10; prev_board[6][7] = 2'b10;
    turn = 1'b1; move_in = 8'h66;
    expect_move(0, 2, 1'b1, 1'b0, 8'h00, 0);
    start_move();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 83) begin failures++; $display("FAIL suicide_latency: got %0d want 83", cyc); end
  endtask

  task automatic test_pass();
    int cyc, bcnt;
    set_ko(8'hFF);
    expect_move(1, 0, 1'b0, 1'b0, 8'h00, 0);
    start_move();
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 83) begin failures++; $display("FAIL pass_latency: got %0d want 83", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt, extra;
    set_single();
    expect_move(1, 0, 1'b0, 1'b0, 8'h00, 0);
    start_move();
    repeat (10) @(negedge clk_in);
    // Second start plus changed inputs mid-scan must both be ignored.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin prev_board[r][c] = 2'b10; next_board[r][c] = 2'b00; end
    start_flag = 1'b1;
    @(negedge clk_in); start_flag = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (cyc + 11 !== 83) begin failures++; $display("FAIL b2b_latency: got %0d want 83", cyc + 11); end
    extra = 0;
    repeat (100) begin @(negedge clk_in); if (done) extra++; end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL b2b_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_reset_midscan();
    int dcnt;
    set_single();
    start_move();
    repeat (40) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    checks++;
    if ({busy, done, captured_last, suicide_last, black_prisoners, white_prisoners, ko_valid, ko_point} !== '0) begin
      failures++; $display("FAIL midscan_reset_outputs: got busy=%0b blk=%0d wht=%0d cap=%0d", busy, black_prisoners, white_prisoners, captured_last);
    end
    exp_black = 0; exp_white = 0;
    @(negedge clk_in); rst_in = 1'b1;
    dcnt = 0;
    repeat (120) begin @(negedge clk_in); if (done) dcnt++; end
    checks++;
    if (dcnt !== 0) begin failures++; $display("FAIL midscan_no_done: got %0d dones want 0", dcnt); end
  endtask

  task automatic test_saturation_clear();
    int cyc, bcnt;
    clear_boards();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) prev_board[r][c] = 2'b10;
    turn = 1'b0; move_in = 8'hFF;
    repeat (3) begin
      expect_move(81, 0, 1'b0, 1'b0, 8'h00, 0);
      start_move(); wait_done(cyc, bcnt);
    end
    clear_boards();
    for (int i = 0; i < 11; i++) prev_board[i / N][i % N] = 2'b10;
    expect_move(11, 0, 1'b0, 1'b0, 8'h00, 0);
    start_move(); wait_done(cyc, bcnt);
    checks++;
    if (black_prisoners !== 8'd254) begin failures++; $display("FAIL preload_254: got %0d want 254", black_prisoners); end
    clear_boards();
    prev_board[2][2] = 2'b10; prev_board[2][3] = 2'b10; prev_board[2][4] = 2'b10;
    expect_move(3, 0, 1'b0, 1'b0, 8'h00, 0);
    start_move(); wait_done(cyc, bcnt);
    checks++;
    if (black_prisoners !== 8'd255) begin failures++; $display("FAIL saturate: got %0d want 255", black_prisoners); end
    // Clear while busy: totals zeroed, this move's adds dropped.
    clear_boards();
    prev_board[1][1] = 2'b10; prev_board[1][2] = 2'b10;
    expect_move(2, 0, 1'b0, 1'b0, 8'h00, 1);
    start_move();
    repeat (20) @(negedge clk_in);
    clear_totals = 1'b1;
    @(negedge clk_in); clear_totals = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (cyc >= 200) begin failures++; $display("FAIL pending_clear_done: got timeout want done"); end
    // Clear in IDLE.
    clear_boards();
    prev_board[0][0] = 2'b10; prev_board[0][1] = 2'b01;
    expect_move(1, 1, 1'b0, 1'b0, 8'h00, 0);
    start_move(); wait_done(cyc, bcnt);
    @(negedge clk_in); clear_totals = 1'b1;
    @(negedge clk_in); clear_totals = 1'b0;
    checks++;
    if (black_prisoners !== 8'd0 || white_prisoners !== 8'd0) begin
      failures++; $display("FAIL idle_clear: got blk=%0d wht=%0d want 0 0", black_prisoners, white_prisoners);
    end
    exp_black = 0; exp_white = 0;
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_ko();
    test_multi_capture();
    test_suicide();
    test_pass();
    test_back_to_back();
    test_reset_midscan();
    test_saturation_clear();
    repeat (3) @(negedge clk_in);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL leftover_expectations: got %0d want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
